if_fetch_stage: RTL
===================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the architectural fetch PC and selects the next PC from sequential, branch redirect and exception redirect.
- Drives the instruction SRAM through a req/addr_ok/data_ok handshake and hands {pc, inst} to IF/ID.
- Drives the IF/ID write-enable and the bubble (fresh) input.

Parameters:
- RESET_PC, 32'h1c000000, first fetch address after reset.
- PRE_PC, 32'h1bfffffc, PC value held during reset; IF/ID never captures this value.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- id_allowin  in  1  IF/ID can accept a new {pc, inst} this cycle.
- br_taken  in  1  branch/jump resolved taken; single-cycle pulse.
- br_target  in  32  branch target; valid with br_taken.
- ex_flush  in  1  exception/ertn redirect; single-cycle pulse; priority over br_taken.
- ex_target  in  32  exception entry or ertn return address.
- inst_sram_req  out  1  fetch request valid.
- inst_sram_addr  out  32  fetch address, word aligned.
- inst_sram_addr_ok  in  1  request accepted this cycle when req=1.
- inst_sram_data_ok  in  1  read data returned this cycle.
- inst_sram_rdata  in  32  instruction word; valid with data_ok.
- if_pc  out  32  PC of the presented instruction; drives IF/ID PC.
- if_inst  out  32  presented instruction; drives IF/ID inst.
- if_valid  out  1  {if_pc, if_inst} valid; drives IF/ID we.
- if_fresh  out  1  one-cycle bubble request to IF/ID on redirect.

Behaviour:
- Reset (rst=0, asynchronous):
  - fetch_pc = PRE_PC and if_pc = PRE_PC.
  - if_inst = 0, if_valid = 0, if_fresh = 0, inst_sram_req = 0.
  - State = REQ.
- First cycle after reset release: inst_sram_req = 1, inst_sram_addr = RESET_PC.
- At most one outstanding request. inst_sram_addr is held stable while req=1 and addr_ok=0.
- States:
  - REQ: req=1, addr = fetch_pc.
    - addr_ok=1: go to WAIT; latch req_pc = addr.
  - WAIT: req=0.
    - data_ok=1 and id_allowin=1: present the word (if_valid=1 for that cycle, if_pc = req_pc, if_inst = rdata); fetch_pc = req_pc+4; go to REQ.
    - data_ok=1 and id_allowin=0: capture rdata into a hold buffer; go to HOLD.
  - HOLD: req=0; if_valid=1 with the buffered word. When id_allowin=1: fetch_pc = req_pc+4; go to REQ.
  - CANCEL: req=0; waits for the stale response. On data_ok: discard the data (if_valid stays 0); go to REQ with fetch_pc = redirect target.
- Zero-latency path: data_ok in WAIT with id_allowin=1 presents the word in the same cycle, combinationally from rdata.
- Redirect (ex_flush, or br_taken without ex_flush): target = ex_target if ex_flush, else br_target. if_fresh=1 for exactly that cycle; if_valid forced 0 that cycle. Effect by state:
  - REQ, addr_ok=0: abandon the request; next cycle req=1 with addr = target.
  - REQ, addr_ok=1: the request is outstanding; go to CANCEL and store the target.
  - WAIT, data_ok=0: go to CANCEL and store the target.
  - WAIT, data_ok=1: discard the data; go to REQ with fetch_pc = target.
  - HOLD: drop the buffered word; go to REQ with fetch_pc = target.
  - CANCEL: overwrite the stored target; the newest redirect wins.
- PC arithmetic: 32-bit, +4 wraps modulo 2^32. Targets with bits [1:0] ≠ 0 are forced to 00; address errors are not detected here.
- if_valid is never 1 while if_pc = PRE_PC.

Test Plan:
- Reset release, addr_ok and data_ok each returned 1 cycle after request, id_allowin=1 → addresses 1c000000, 1c000004, 1c000008; if_valid pulses with matching if_pc/if_inst; no request at 1bfffffc.
- data_ok at 1c000000 while id_allowin=0 for 3 cycles → if_valid held 3 cycles with the same inst, req=0; next request 1c000004 only after id_allowin rises.
- br_taken (target 1c000100) in WAIT, data_ok 2 cycles later → if_fresh one cycle, stale data not presented, next addr 1c000100.
- ex_flush (1c008000) and br_taken (1c000100) in the same cycle → next addr 1c008000.
- Redirect in REQ with addr_ok=0 → req stays 1; address switches to target next cycle; no CANCEL entered.
- rst asserted mid-WAIT → outputs reset immediately (asynchronous); after release the first request is 1c000000; the late data_ok from the old request is ignored.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, runs the instruction SRAM
// req/addr_ok/data_ok handshake with at most one request in flight, and
// hands {pc, inst} plus write-enable and bubble requests to the IF/ID register.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000,
    parameter logic [31:0] PRE_PC   = 32'h1bfffffc
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_allowin,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        ex_flush,
    input  logic [31:0] ex_target,
    output logic        inst_sram_req,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid,
    output logic        if_fresh
);

    typedef enum logic [1:0] {
        S_REQ    = 2'd0,
        S_WAIT   = 2'd1,
        S_HOLD   = 2'd2,
        S_CANCEL = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_first;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_req_pc;
    logic [31:0] r_hold_inst;
    logic [31:0] r_cancel_target;

    logic        w_redirect;
    logic [31:0] w_target_raw;
    logic [31:0] w_target;
    logic [31:0] w_req_addr;
    logic [31:0] w_seq_pc;
    logic        w_present;

    // Exception redirect outranks a branch; targets are forced word aligned.
    assign w_redirect   = ex_flush | br_taken;
    assign w_target_raw = ex_flush ? ex_target : br_target;
    assign w_target     = w_target_raw & ~32'h3;

    // Until the first request is issued the fetch PC still holds PRE_PC,
    // so the very first request goes out at RESET_PC instead.
    assign w_req_addr   = r_first ? RESET_PC : r_fetch_pc;
    assign w_seq_pc     = r_req_pc + 32'd4;

    assign inst_sram_req  = rst && (r_state == S_REQ);
    assign inst_sram_addr = w_req_addr;

    // A word is offered either straight from the SRAM (zero-latency path) or from the hold buffer.
    assign w_present = ((r_state == S_WAIT) && inst_sram_data_ok && id_allowin) ||
                       (r_state == S_HOLD);
    assign if_valid  = rst && w_present && !w_redirect;
    assign if_fresh  = rst && w_redirect;
    assign if_pc     = r_req_pc;

    // Select the instruction word shown to IF/ID: buffered word in HOLD, live SRAM data otherwise.
    always_comb begin
        if_inst = 32'h0;
        if (r_state == S_HOLD) begin
            if_inst = r_hold_inst;
        end else if ((r_state == S_WAIT) && inst_sram_data_ok) begin
            if_inst = inst_sram_rdata;
        end
    end

    // Fetch control FSM: request, wait for data, hold for IF/ID, or drain a cancelled request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= S_REQ;
            r_first         <= 1'b1;
            r_fetch_pc      <= PRE_PC;
            r_req_pc        <= PRE_PC;
            r_hold_inst     <= 32'h0;
            r_cancel_target <= 32'h0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_redirect) begin
                        r_first <= 1'b0;
                        if (inst_sram_addr_ok) begin
                            r_cancel_target <= w_target;
                            r_state         <= S_CANCEL;
                        end else begin
                            r_fetch_pc <= w_target;
                        end
                    end else if (inst_sram_addr_ok) begin
                        r_first  <= 1'b0;
                        r_req_pc <= w_req_addr;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_redirect) begin
                        if (inst_sram_data_ok) begin
                            r_fetch_pc <= w_target;
                            r_state    <= S_REQ;
                        end else begin
                            r_cancel_target <= w_target;
                            r_state         <= S_CANCEL;
                        end
                    end else if (inst_sram_data_ok) begin
                        if (id_allowin) begin
                            r_fetch_pc <= w_seq_pc;
                            r_state    <= S_REQ;
                        end else begin
                            r_hold_inst <= inst_sram_rdata;
                            r_state     <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_redirect) begin
                        r_fetch_pc <= w_target;
                        r_state    <= S_REQ;
                    end else if (id_allowin) begin
                        r_fetch_pc <= w_seq_pc;
                        r_state    <= S_REQ;
                    end
                end
                S_CANCEL: begin
                    if (w_redirect) begin
                        r_cancel_target <= w_target;
                    end
                    if (inst_sram_data_ok) begin
                        r_fetch_pc <= w_redirect ? w_target : r_cancel_target;
                        r_state    <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_REQ;
                end
            endcase
        end
    end

endmodule
